// File: rtl/masked_ascon_sublayer_seq_if.sv
// Handshake and two-share state bus for the column-serial masked Ascon S-box layer.
interface masked_ascon_sublayer_seq_if #(
  parameter int unsigned W = 64
);
  logic           in_valid;
  logic           in_ready;
  logic [5*W-1:0] a_state_in;
  logic [5*W-1:0] b_state_in;
  logic [4:0]     z_in;
  logic           z_req;
  logic           out_valid;
  logic           out_ready;
  logic [5*W-1:0] a_state_out;
  logic [5*W-1:0] b_state_out;
  logic           busy;

  modport master (
    output in_valid, a_state_in, b_state_in, z_in, out_ready,
    input  in_ready, z_req, out_valid, a_state_out, b_state_out, busy
  );

  modport slave (
    input  in_valid, a_state_in, b_state_in, z_in, out_ready,
    output in_ready, z_req, out_valid, a_state_out, b_state_out, busy
  );
endinterface

// File: rtl/masked_ascon_sublayer_seq.sv
// Two-share Ascon substitution layer: one first-order DOM S-box walked over all W columns.
// Optional macro ASCON_SBOX_LFSR_EN sources the DOM randomness from an internal LFSR instead of z_in.
module masked_ascon_sublayer_seq #(
  parameter int unsigned W         = 64,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2B07
) (
  input logic                        clk,
  input logic                        rst,
  masked_ascon_sublayer_seq_if.slave bus
);
  localparam int unsigned   CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, CAPTURE, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [4:0][W-1:0] a_sh, b_sh;
  logic [4:0][W-1:0] a_out_q, b_out_q;
  logic [4:0]        z_q, z_next;
  logic              z_take;
  logic [4:0]        cross_ab_q, cross_ba_q, cross_ab_d, cross_ba_d;
  logic [4:0]        ax, bx, ay, by;
  logic [4:0]        la, lb, ma, mb;
  logic              out_valid_q, busy_q, in_ready_q;

  // current column; index 4 carries lane x0
  for (genvar j = 0; j < 5; j++) begin : g_col
    assign ax[j] = a_sh[j][col];
    assign bx[j] = b_sh[j][col];
  end

  // input linear layer per share, la/lb indexed by lane number x0..x4
  assign la[0] = ax[4] ^ ax[0];
  assign la[1] = ax[3];
  assign la[2] = ax[2] ^ ax[3];
  assign la[3] = ax[1];
  assign la[4] = ax[0] ^ ax[1];
  assign lb[0] = bx[4] ^ bx[0];
  assign lb[1] = bx[3];
  assign lb[2] = bx[2] ^ bx[3];
  assign lb[3] = bx[1];
  assign lb[4] = bx[0] ^ bx[1];

  // chi with DOM ANDs: inner-domain terms combinational, cross-domain terms reshared and registered
  for (genvar i = 0; i < 5; i++) begin : g_chi
    localparam int unsigned I1 = (i + 1) % 5;
    localparam int unsigned I2 = (i + 2) % 5;
    logic pa, pb, qa, qb;
    assign pa            = ~la[I1];
    assign pb            = lb[I1];
    assign qa            = la[I2];
    assign qb            = lb[I2];
    assign cross_ab_d[i] = (pa & qb) ^ z_q[i];
    assign cross_ba_d[i] = (pb & qa) ^ z_q[i];
    assign ma[i]         = la[i] ^ (pa & qa) ^ cross_ab_q[i];
    assign mb[i]         = lb[i] ^ (pb & qb) ^ cross_ba_q[i];
  end

  // output linear layer; the constant inversion lands on share A only
  assign ay[4] = ma[0] ^ ma[4];
  assign ay[3] = ma[1] ^ ma[0];
  assign ay[2] = ~ma[2];
  assign ay[1] = ma[3] ^ ma[2];
  assign ay[0] = ma[4];
  assign by[4] = mb[0] ^ mb[4];
  assign by[3] = mb[1] ^ mb[0];
  assign by[2] = mb[2];
  assign by[1] = mb[3] ^ mb[2];
  assign by[0] = mb[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cross_ab_q <= '0;
      cross_ba_q <= '0;
    end else if (state == PRESENT) begin
      cross_ab_q <= cross_ab_d;
      cross_ba_q <= cross_ba_d;
    end
  end

  // z is taken on the accept edge and on every capture edge that moves to a new column
  always_comb begin
    z_take = 1'b0;
    if ((state == IDLE) && bus.in_valid) z_take = 1'b1;
    if ((state == CAPTURE) && (col != LAST_COL)) z_take = 1'b1;
  end

`ifdef ASCON_SBOX_LFSR_EN
  logic [31:0] lfsr_q;
  logic [4:0]  unused_z_in;
  assign unused_z_in = bus.z_in;
  assign z_next      = lfsr_q[4:0];

  // Galois LFSR, taps 32,22,2,1, one step per z sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (z_take) begin
      lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0000_0000);
    end
  end
`else
  logic [31:0] unused_seed;
  assign unused_seed = LFSR_SEED;
  assign z_next      = bus.z_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a_state_in;
            b_sh       <= bus.b_state_in;
            col        <= '0;
            z_q        <= z_next;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= PRESENT;
          end
        end
        PRESENT: state <= CAPTURE;
        CAPTURE: begin
          a_out_q[0][col] <= ay[0];
          a_out_q[1][col] <= ay[1];
          a_out_q[2][col] <= ay[2];
          a_out_q[3][col] <= ay[3];
          a_out_q[4][col] <= ay[4];
          b_out_q[0][col] <= by[0];
          b_out_q[1][col] <= by[1];
          b_out_q[2][col] <= by[2];
          b_out_q[3][col] <= by[3];
          b_out_q[4][col] <= by[4];
          if (col == LAST_COL) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            col   <= col + CW'(1);
            z_q   <= z_next;
            state <= PRESENT;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.z_req       = z_take;
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.a_state_out = a_out_q;
  assign bus.b_state_out = b_out_q;
endmodule
